// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// for a shared-memory datapath, with a memory-ready handshake, a not-ready
// timeout that halts the core, and a retired-instruction (fetch) counter.
//
// state     | meaning
// ----------+----------------------------------------------
// FETCH     | read instruction at PC, load IR, PC <= PC+4
// DECODE    | register read, branch target into ALUOut
// MEM_ADDR  | effective address rs + imm
// MEM_READ  | data read at ALUOut
// MEM_WB    | load data (MDR) into rt
// MEM_WRITE | data write at ALUOut
// EXEC_R    | R-type ALU operation rs op rt
// R_WB      | ALUOut into rd
// BRANCH    | rs - rt compare, conditional PC <= ALUOut
// JUMP      | PC <= jump target
// EXEC_I    | I-type ALU operation rs op imm
// I_WB      | ALUOut into rt
// JR        | PC <= rs
// HALT      | illegal opcode or memory timeout; sticky until reset
module multicycle_control #(
  parameter int MEM_WAIT  = 1,
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCEn,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [5:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 Halted,
  output logic [3:0]           State,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    I_WB      = 4'd11,
    JR        = 4'd12,
    HALT      = 4'd13
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [5:0] ALU_ADD  = 6'h08;
  localparam logic [5:0] ALU_SUB  = 6'h04;
  localparam logic [5:0] ALU_R    = 6'h00;

  // Wait counter only needs to reach TIMEOUT-1: the terminal cycle itself
  // is detected combinationally and diverts to HALT.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  stateT             curState;
  stateT             nxtState;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNext;
  logic              readyEff;
  logic              memState;
  logic              timeoutHit;

  assign readyEff   = (MEM_WAIT != 0) ? MemReady : 1'b1;
  assign memState   = (curState == FETCH) || (curState == MEM_READ) || (curState == MEM_WRITE);
  assign timeoutHit = (TIMEOUT != 0) && memState && !readyEff && (waitCnt == WAIT_TC);
  assign State      = curState;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) curState <= FETCH;
    else        curState <= nxtState;
  end

  // Next-state decode; a timeout overrides any stay-in-place wait
  always_comb begin
    nxtState = curState;
    case (curState)
      FETCH:     if (readyEff) nxtState = DECODE;
      DECODE: begin
        case (OP)
          OP_LW, OP_SW:             nxtState = MEM_ADDR;
          OP_RTYPE:                 nxtState = (Funct == FN_JR) ? JR : EXEC_R;
          OP_BEQ, OP_BNE:           nxtState = BRANCH;
          OP_J:                     nxtState = JUMP;
          OP_ADDI, OP_ORI, OP_LUI:  nxtState = EXEC_I;
          default:                  nxtState = HALT;
        endcase
      end
      MEM_ADDR:  nxtState = (OP == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (readyEff) nxtState = MEM_WB;
      MEM_WRITE: if (readyEff) nxtState = FETCH;
      EXEC_R:    nxtState = R_WB;
      EXEC_I:    nxtState = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP, JR: nxtState = FETCH;
      HALT:      nxtState = HALT;
      default:   nxtState = HALT;
    endcase
    if (timeoutHit) nxtState = HALT;
  end

  // Output decode; write/request enables are gated off while reset is held
  always_comb begin
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_R;
    PCSource = 2'b00;
    Halted   = 1'b0;
    case (curState)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        IRWrite = readyEff;
        PCEn    = readyEff;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_R;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCEn     = (OP == OP_BNE) ? ~Zero : Zero;
      end
      JUMP: begin
        PCSource = 2'b10;
        PCEn     = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = OP;
      end
      I_WB:     RegWrite = 1'b1;
      JR: begin
        PCSource = 2'b11;
        PCEn     = 1'b1;
      end
      HALT:     Halted = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // Consecutive not-ready count; restarts on ready or on leaving the state
  always_comb begin
    waitNext = '0;
    if (memState && !readyEff && !timeoutHit)
      waitNext = (waitCnt == '1) ? waitCnt : waitCnt + 1'b1;
  end

  // Wait counter and retired-fetch counter (wraps naturally)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt    <= '0;
      InstrCount <= '0;
    end else begin
      waitCnt <= waitNext;
      if (curState == FETCH && readyEff) InstrCount <= InstrCount + 1'b1;
    end
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle successor to the single-cycle MIPS control unit. A registered state machine sequences each instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles, driving a shared-memory multicycle datapath. Memory accesses use a ready handshake with a configurable wait-timeout. The block also keeps a retired-instruction counter. It sits between the instruction register and the multicycle datapath muxes, register file and memory.

## Interface
- MEM_WAIT, 1, selects memory mode: 1 honours MemReady; 0 treats MemReady as constant 1.
- TIMEOUT, 15, consecutive not-ready cycles before halting; 0 disables the timeout.
- CNT_WIDTH, 16, width of InstrCount.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- OP  in  6  opcode, IR[31:26].
- Funct  in  6  function field, IR[5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access complete this cycle.
- PCEn  out  1  PC register write enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- ALUOp  out  6  ALU operation code.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- Halted  out  1  sticky; set by an illegal opcode or a memory timeout.
- State  out  4  current state encoding, for debug.
- InstrCount  out  CNT_WIDTH  count of completed fetches.

## Operation
- Supported opcodes:
  - R-type 0x00, with JR when Funct = 0x08.
  - J 0x02, BEQ 0x04, BNE 0x05.
  - ADDI 0x08, ORI 0x0D, LUI 0x0F.
  - LW 0x23, SW 0x2B.
- ALUOp codes:
  - ADD = 0x08.
  - SUB = 0x04.
  - R-type = 0x00.
  - I-type passes OP through.
- Any output not listed for a state is 0.
- States and transitions:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00. IRWrite and PCEn equal the effective MemReady. On ready go to DECODE; otherwise stay.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD.
    - LW/SW go to MEM_ADDR.
    - R-type goes to EXEC_R; JR goes to JR.
    - BEQ/BNE go to BRANCH; J goes to JUMP.
    - ADDI/ORI/LUI go to EXEC_I.
    - Any other opcode goes to HALT.
  - MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Goes to MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ (3): MemRead=1, IorD=1. On ready go to MEM_WB.
  - MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
  - MEM_WRITE (5): MemWrite=1, IorD=1. On ready go to FETCH.
  - EXEC_R (6): ALUSrcA=1, ALUSrcB=00, ALUOp=0x00. Then R_WB.
  - R_WB (7): RegWrite=1, RegDst=1. Then FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01. PCEn=Zero for BEQ, PCEn=~Zero for BNE. Then FETCH.
  - JUMP (9): PCSource=10, PCEn=1. Then FETCH.
  - EXEC_I (10): ALUSrcA=1, ALUSrcB=10, ALUOp=OP. Then I_WB.
  - I_WB (11): RegWrite=1, RegDst=0. Then FETCH.
  - JR (12): PCSource=11, PCEn=1. Then FETCH.
  - HALT (13): all enables 0, Halted=1. Remains in HALT until reset.
- Wait counter:
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with MemReady=0.
  - Clears on MemReady=1 or on any state change.
  - When MEM_WAIT=1, TIMEOUT≠0 and the count reaches TIMEOUT, the next state is HALT instead of a further wait cycle.
- InstrCount increments on each FETCH cycle with effective ready and wraps modulo 2^CNT_WIDTH.

## Timing
- State, wait counter and InstrCount are registered on the rising edge of clk.
- Outputs are combinational from state, plus OP/Zero/MemReady where listed above.
- While reset=0:
  - State=FETCH, counter=0, InstrCount=0, Halted=0.
  - PCEn, IRWrite, MemRead, MemWrite and RegWrite are forced to 0.
  - All other outputs take their FETCH values.
- Reset asserted mid-instruction returns to FETCH immediately, with no writeback.
- Zero-wait latency:
  - Branch, J and JR: 3 cycles.
  - R-type, I-type and SW: 4 cycles.
  - LW: 5 cycles.
  - Each MemReady=0 cycle adds one cycle.
- OP and Funct need to be stable only from DECODE onward; IR is loaded at the end of FETCH.
- MemReady is sampled only in the three memory states; it is ignored elsewhere.

## Test plan
- R-type then ADDI with MemReady held at 1 (MEM_WAIT=1): State sequence 0,1,6,7,0,1,10,11,0. RegDst=1 in R_WB, ALUOp=0x08 in EXEC_I. InstrCount=2 after the two fetches.
- LW with 3 not-ready cycles in FETCH and 2 in MEM_READ: 10 cycles total. IRWrite and PCEn pulse exactly once. MemtoReg=RegWrite=1 for 1 cycle in MEM_WB.
- BEQ with Zero=1 gives PCEn=1, PCSource=01. BNE with Zero=1 gives PCEn=0. Each returns to FETCH after 3 cycles.
- JR (OP=0, Funct=0x08) visits state 12 with PCSource=11, PCEn=1. Opcode 0x3F goes to HALT; Halted stays 1 for 20 cycles; reset clears it.
- TIMEOUT=15 with MemReady=0 in MEM_WRITE: after 15 wait cycles State=13 and MemWrite=0. With TIMEOUT=0, no halt occurs after 100 cycles.
- Assert reset in MEM_WB: RegWrite drops to 0 immediately, and State=0 and InstrCount=0 asynchronously. With CNT_WIDTH=4, 17 instructions give InstrCount=1.
